// File: rtl/seg_display_reader_pkg.sv
// ----------------------------------------------------------------------------
// seg_display_reader_pkg
//   Definitions shared by the 7-segment display encoder and this reader:
//   - active-low segment codes for digits 0..3 and the blank screen
//   - segment bit positions within the {DP,G,F,E,D,C,B,A} bus
//   - reader FSM state encoding
//   - decode helper that maps a segment pattern to digit/blank/err
// ----------------------------------------------------------------------------
package seg_display_reader_pkg;

    // Segment bit positions, bus order {DP,G,F,E,D,C,B,A}
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-low codes (0 = segment lit)
    localparam logic [7:0] SEG_0     = 8'h40;
    localparam logic [7:0] SEG_1     = 8'h79;
    localparam logic [7:0] SEG_2     = 8'h24;
    localparam logic [7:0] SEG_3     = 8'h30;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Reader FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Decoded view of one settled pattern
    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       err;
    } seg_dec_t;

    // Blank and err both report digit 0 so a consumer never sees a stale digit.
    function automatic seg_dec_t seg_decode(input logic [7:0] pat);
        seg_dec_t d;
        d = '0;
        case (pat)
            SEG_0:     d.digit = 4'd0;
            SEG_1:     d.digit = 4'd1;
            SEG_2:     d.digit = 4'd2;
            SEG_3:     d.digit = 4'd3;
            SEG_BLANK: d.blank = 1'b1;
            default:   d.err   = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_sync_stable.sv
// ----------------------------------------------------------------------------
// seg_sync_stable
//   Brings the asynchronous segment lines into the clk domain and filters
//   glitches: a pattern is accepted only after STABLE_CYCLES consecutive
//   identical synchronised samples.
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   seg_n       in   8  raw segment lines {DP,G,F,E,D,C,B,A}
//   stable_pat  out  8  last accepted pattern (resets to blank 8'hFF)
//   stable_chg  out  1  one-cycle flag: stable_pat took a new value on the last edge
// ----------------------------------------------------------------------------
module seg_sync_stable #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_n,
    output logic [7:0] stable_pat,
    output logic       stable_chg
);

    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [7:0]       prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             match;
    logic             upd;

    // cnt counts matching sample pairs. Acceptance happens on the edge where
    // cnt becomes STABLE_CYCLES-1, i.e. when STABLE_CYCLES identical samples
    // have been seen. cnt saturates at STABLE_CYCLES so the acceptance fires
    // only once per settled pattern.
    always_comb begin
        match    = (sync2 == prev);
        cnt_next = cnt;
        if (!match) begin
            cnt_next = '0;
        end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
            cnt_next = cnt + 1'b1;
        end
        if (STABLE_CYCLES == 1) begin
            // A single sample is already "stable": follow sync2 directly.
            upd = 1'b1;
        end else begin
            upd = match && (cnt_next == CNT_W'(STABLE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 8'hFF;
            sync2      <= 8'hFF;
            prev       <= 8'hFF;
            cnt        <= '0;
            stable_pat <= 8'hFF;
            stable_chg <= 1'b0;
        end else begin
            sync1      <= seg_n;
            sync2      <= sync1;
            prev       <= sync2;
            cnt        <= cnt_next;
            if (upd) begin
                stable_pat <= sync2;
            end
            stable_chg <= upd && (sync2 != stable_pat);
        end
    end

endmodule

// File: rtl/seg_display_reader.sv
// ----------------------------------------------------------------------------
// seg_display_reader
//   Receive side of the 7-segment display link. Settled segment patterns are
//   decoded to digit 0..3 / blank / invalid and offered to a consumer as one
//   event per change of the settled pattern.
//
//   Handshake: out_valid rises with all out_* fields loaded; the fields are
//   frozen until an edge with out_valid && out_ready, on which out_valid
//   drops. The next event can load no earlier than the following edge.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   seg_n      in   8  async segment lines {DP,G,F,E,D,C,B,A}, 0 = lit
//   out_ready  in   1  consumer ready
//   out_valid  out  1  event pending
//   out_digit  out  4  decoded digit (0 for blank/err)
//   out_blank  out  1  pattern was blank (8'hFF)
//   out_err    out  1  pattern matched no legal code
//   out_raw    out  8  accepted pattern
//   overrun    out  1  one-cycle pulse: a new pattern settled while the slot was full
//   fsm_state  out  1  current FSM state (debug)
// ----------------------------------------------------------------------------
module seg_display_reader
    import seg_display_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_n,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_blank,
    output logic       out_err,
    output logic [7:0] out_raw,
    output logic       overrun,
    output state_t     fsm_state
);

    logic [7:0] stable_pat;
    logic       stable_chg;
    logic [7:0] rep_pat;
    state_t     state;
    state_t     state_next;
    logic       load;
    logic       drain;
    seg_dec_t   dec;

    seg_sync_stable #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_sync_stable (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_n      (seg_n),
        .stable_pat (stable_pat),
        .stable_chg (stable_chg)
    );

    assign dec       = seg_decode(stable_pat);
    assign fsm_state = state;

    // Next-state logic. In HOLD out_valid is always 1, so out_ready alone
    // completes the handshake.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drain      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stable_pat != rep_pat) begin
                    load       = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    drain      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output slot and last-reported pattern. rep_pat only moves on a load, so
    // a pattern that settles while the slot is full is reported after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_digit <= 4'd0;
            out_blank <= 1'b0;
            out_err   <= 1'b0;
            out_raw   <= 8'hFF;
            rep_pat   <= 8'hFF;
        end else if (load) begin
            out_valid <= 1'b1;
            out_digit <= dec.digit;
            out_blank <= dec.blank;
            out_err   <= dec.err;
            out_raw   <= stable_pat;
            rep_pat   <= stable_pat;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // stable_chg already guarantees the new pattern differs from the prior
    // stable one; it must also differ from what the held slot reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= (state == ST_HOLD) && !out_ready && stable_chg
                       && (stable_pat != rep_pat);
        end
    end

endmodule

// File: tb/tb_seg_display_reader.sv
// ----------------------------------------------------------------------------
// tb_seg_display_reader
//   Directed bench for seg_display_reader with STABLE_CYCLES=4. Inputs change
//   1 time unit after a rising edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_seg_display_reader;
    import seg_display_reader_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg_n;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_blank;
    logic       out_err;
    logic [7:0] out_raw;
    logic       overrun;
    state_t     fsm_state;

    int checks   = 0;
    int failures = 0;
    int n_valid;
    int n_ovr;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg_display_reader #(
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_n     (seg_n),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_blank (out_blank),
        .out_err   (out_err),
        .out_raw   (out_raw),
        .overrun   (overrun),
        .fsm_state (fsm_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance n edges, counting samples with out_valid and overrun high.
    task automatic watch(input int n, output int valid_cnt, output int ovr_cnt);
        valid_cnt = 0;
        ovr_cnt   = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (out_valid) valid_cnt++;
            if (overrun)   ovr_cnt++;
        end
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_event(input string tag, input logic [3:0] digit, input logic blank,
                             input logic err, input logic [7:0] raw);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_digit"}, 32'(out_digit), 32'(digit));
        chk({tag, "_blank"}, 32'(out_blank), 32'(blank));
        chk({tag, "_err"},   32'(out_err),   32'(err));
        chk({tag, "_raw"},   32'(out_raw),   32'(raw));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        seg_n     = 8'hFF;
        out_ready = 1'b0;
        tick(3);

        // Reset state
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_digit",   32'(out_digit), 32'd0);
        chk("rst_blank",   32'(out_blank), 32'd0);
        chk("rst_err",     32'(out_err),   32'd0);
        chk("rst_raw",     32'(out_raw),   32'hFF);
        chk("rst_overrun", 32'(overrun),   32'd0);
        chk("rst_state",   32'(fsm_state), 32'(ST_IDLE));
        rst_n = 1'b1;

        // 1. Blank screen at power-up: no event, no overrun
        watch(50, n_valid, n_ovr);
        chk("pwrup_valid_cnt", 32'(n_valid), 32'd0);
        chk("pwrup_ovr_cnt",   32'(n_ovr),   32'd0);

        // 2. Digit 2: pins constant from edge k, out_valid after edge k+6
        out_ready = 1'b1;
        seg_n     = 8'h24;
        tick(6);
        chk("d2_early_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk_event("d2", 4'd2, 1'b0, 1'b0, 8'h24);
        tick(1);
        chk("d2_accepted", 32'(out_valid), 32'd0);

        // 3. Digit 3, then a 3-clock glitch to 1 (ignored), then a real 1
        seg_n = 8'h30;
        tick(7);
        chk_event("d3", 4'd3, 1'b0, 1'b0, 8'h30);
        tick(10);
        seg_n = 8'h79;
        tick(3);
        seg_n = 8'h30;
        watch(15, n_valid, n_ovr);
        chk("glitch_valid_cnt", 32'(n_valid), 32'd0);
        seg_n = 8'h79;
        tick(7);
        chk_event("d1", 4'd1, 1'b0, 1'b0, 8'h79);
        tick(1);
        chk("d1_accepted", 32'(out_valid), 32'd0);

        // Same pattern settling again after a glitch: no new event
        seg_n = 8'h24;
        tick(2);
        seg_n = 8'h79;
        watch(15, n_valid, n_ovr);
        chk("resettle_valid_cnt", 32'(n_valid), 32'd0);

        // 4. Slot full: 0 held, 3 settles behind it -> one overrun pulse
        out_ready = 1'b0;
        seg_n     = 8'h40;
        tick(7);
        chk_event("d0_hold", 4'd0, 1'b0, 1'b0, 8'h40);
        chk("d0_state", 32'(fsm_state), 32'(ST_HOLD));
        seg_n = 8'h30;
        watch(12, n_valid, n_ovr);
        chk("full_valid_cnt", 32'(n_valid), 32'd12);
        chk("full_ovr_cnt",   32'(n_ovr),   32'd1);
        chk_event("d0_frozen", 4'd0, 1'b0, 1'b0, 8'h40);
        out_ready = 1'b1;
        tick(1);
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_state", 32'(fsm_state), 32'(ST_IDLE));
        tick(1);
        chk_event("d3_after", 4'd3, 1'b0, 1'b0, 8'h30);
        tick(1);
        chk("d3_after_accepted", 32'(out_valid), 32'd0);

        // 5. Illegal pattern, then blank
        seg_n = 8'h00;
        tick(7);
        chk_event("err", 4'd0, 1'b0, 1'b1, 8'h00);
        tick(1);
        seg_n = 8'hFF;
        tick(7);
        chk_event("blank", 4'd0, 1'b1, 1'b0, 8'hFF);
        tick(1);

        // 6. Reset while an event is held: out_valid drops with no clock edge
        out_ready = 1'b0;
        seg_n     = 8'h24;
        tick(7);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_state", 32'(fsm_state), 32'(ST_IDLE));
        chk("async_rst_raw",   32'(out_raw),   32'hFF);
        seg_n = 8'hFF;
        tick(3);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        watch(20, n_valid, n_ovr);
        chk("post_rst_valid_cnt", 32'(n_valid), 32'd0);
        chk("post_rst_ovr_cnt",   32'(n_ovr),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
